// File: rtl/mult_datapath_if.sv
// Controller <-> datapath bundle for the shift-add signed multiplier.
// The master is the controller: it drives strobes and operands and observes M, K and Product.
interface mult_datapath_if #(
  parameter int N = 4
);
  logic           Load;
  logic           Rshift;
  logic           AddRshift;
  logic           Cm;
  logic [N-1:0]   Mplier;
  logic [N-1:0]   Mcand;
  logic           M;
  logic           K;
  logic [2*N-1:0] Product;

  modport master (
    output Load, Rshift, AddRshift, Cm, Mplier, Mcand,
    input  M, K, Product
  );

  modport slave (
    input  Load, Rshift, AddRshift, Cm, Mplier, Mcand,
    output M, K, Product
  );
endinterface

// File: rtl/mult_datapath.sv
// Shift-add signed multiplier datapath; Product is valid one Load edge plus N step edges later.
// No backpressure: one strobe is acted on per edge (Reset > Load > AddRshift > Rshift), idle cycles hold.
module mult_datapath #(
  parameter int N = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  mult_datapath_if.slave  bus
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;

  logic [N:0]    w_addend;
  logic [N:0]    w_sum;
  logic          w_last;
  logic [CW-1:0] w_cnt_nxt;

  // Sign-extending to N+1 bits keeps the negation of the most-negative multiplicand exact.
  always_comb begin
    w_addend  = bus.Cm ? -{r_b[N-1], r_b} : {r_b[N-1], r_b};
    w_sum     = {r_a[N-1], r_a} + w_addend;
    w_last    = (r_cnt == CW'(N - 1));
    w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_a   <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (bus.Load) begin
      r_a   <= '0;
      r_q   <= bus.Mplier;
      r_b   <= bus.Mcand;
      r_cnt <= '0;
    end else if (bus.AddRshift) begin
      r_a   <= w_sum[N:1];
      r_q   <= {w_sum[0], r_q[N-1:1]};
      r_cnt <= w_cnt_nxt;
    end else if (bus.Rshift) begin
      r_a   <= {r_a[N-1], r_a[N-1:1]};
      r_q   <= {r_a[0], r_q[N-1:1]};
      r_cnt <= w_cnt_nxt;
    end
  end

  assign bus.M       = r_q[0];
  assign bus.K       = w_last;
  assign bus.Product = {r_a, r_q};
endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: directed cases plus randomized operands against an integer product model.
module tb_mult_datapath;
  localparam int N = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mult_datapath_if #(.N(N)) bus ();

  mult_datapath #(.N(N)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // One clock edge with the given controls; strobes return low afterwards.
  task automatic apply(input logic rst, input logic ld, input logic rs, input logic ar,
                       input logic cm, input logic [N-1:0] mp, input logic [N-1:0] mc);
    Reset = rst; bus.Load = ld; bus.Rshift = rs; bus.AddRshift = ar; bus.Cm = cm;
    bus.Mplier = mp; bus.Mcand = mc;
    @(posedge CLK);
    #1;
    Reset = 1'b0; bus.Load = 1'b0; bus.Rshift = 1'b0; bus.AddRshift = 1'b0; bus.Cm = 1'b0;
  endtask

  // Bench-side controller: step i examines multiplier bit i; subtract only on the last step.
  task automatic step_for(input logic [N-1:0] mp, input int i, input logic extra_rs);
    if (mp[i]) apply(1'b0, 1'b0, extra_rs, 1'b1, (i == N - 1), '0, '0);
    else       apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] mp, input logic [N-1:0] mc);
    int p;
    logic [31:0] pv;
    p  = int'($signed(mp)) * int'($signed(mc));
    pv = p;
    return pv[2*N-1:0];
  endfunction

  task automatic test_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h5);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h5);
    total++; if (bus.Product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h exp=00", bus.Product); end
    total++; if (bus.M !== 1'b0) begin bad++; $display("FAIL reset_M got=%b exp=0", bus.M); end
    total++; if (bus.K !== 1'b0) begin bad++; $display("FAIL reset_K got=%b exp=0", bus.K); end
  endtask

  task automatic test_neg_times_pos();
    logic [N-1:0] mp = 4'b1011;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, 4'b0011);
    total++; if (bus.M !== 1'b1 || bus.K !== 1'b0) begin bad++; $display("FAIL negpos_load M/K got=%b%b exp=10", bus.M, bus.K); end
    for (int i = 0; i < N; i++) begin
      step_for(mp, i, 1'b0);
      total++; if (bus.K !== (i == N - 2)) begin bad++; $display("FAIL negpos_K step=%0d got=%b exp=%b", i, bus.K, (i == N - 2)); end
    end
    total++; if (bus.Product !== 8'hF1) begin bad++; $display("FAIL negpos_product got=%h exp=f1", bus.Product); end
  endtask

  task automatic test_most_negative();
    logic [N-1:0] mp = 4'b1000;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, 4'b1000);
    for (int i = 0; i < N; i++) step_for(mp, i, 1'b0);
    total++; if (bus.Product !== 8'h40) begin bad++; $display("FAIL mostneg_product got=%h exp=40", bus.Product); end
    total++; if (bus.K !== 1'b0) begin bad++; $display("FAIL mostneg_K got=%b exp=0", bus.K); end
  endtask

  task automatic test_m_tracking();
    logic [N-1:0] mp = 4'b0101;
    logic exp_m [N] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, 4'b0011);
    for (int i = 0; i < N; i++) begin
      total++; if (bus.M !== exp_m[i]) begin bad++; $display("FAIL mtrack step=%0d got=%b exp=%b", i, bus.M, exp_m[i]); end
      step_for(mp, i, 1'b0);
    end
    total++; if (bus.Product !== 8'h0F) begin bad++; $display("FAIL mtrack_product got=%h exp=0f", bus.Product); end
  endtask

  task automatic test_mid_reset_load();
    logic [N-1:0] mp = 4'b0101;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, 4'b0011);
    step_for(mp, 0, 1'b0);
    step_for(mp, 1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    total++; if (bus.Product !== 8'h00 || bus.M !== 1'b0 || bus.K !== 1'b0)
      begin bad++; $display("FAIL midreset got P=%h M=%b K=%b exp P=00 M=0 K=0", bus.Product, bus.M, bus.K); end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1111);
    total++; if (bus.Product !== 8'h01 || bus.M !== 1'b1 || bus.K !== 1'b0)
      begin bad++; $display("FAIL loadwins got P=%h M=%b K=%b exp P=01 M=1 K=0", bus.Product, bus.M, bus.K); end
    for (int i = 0; i < N; i++) begin
      step_for(4'b0001, i, 1'b0);
      total++; if (bus.K !== (i == N - 2)) begin bad++; $display("FAIL loadwins_K step=%0d got=%b exp=%b", i, bus.K, (i == N - 2)); end
    end
    total++; if (bus.Product !== 8'hFF) begin bad++; $display("FAIL loadwins_product got=%h exp=ff", bus.Product); end
  endtask

  task automatic test_idle_hold();
    logic [N-1:0] mp = 4'b0111;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, 4'b0110);
    for (int i = 0; i < N; i++) step_for(mp, i, 1'b0);
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h5);
      total++; if (bus.Product !== 8'h2A || bus.M !== 1'b0 || bus.K !== 1'b0)
        begin bad++; $display("FAIL idle cyc=%0d got P=%h M=%b K=%b exp P=2a M=0 K=0", c, bus.Product, bus.M, bus.K); end
    end
  endtask

  // Random operands, back to back; a stray Rshift alongside AddRshift must lose.
  task automatic test_back_to_back_random();
    logic [N-1:0] mp, mc;
    logic [2*N-1:0] exp_p;
    logic exp_m;
    for (int t = 0; t < 40; t++) begin
      mp = N'($urandom);
      mc = N'($urandom);
      exp_p = ref_prod(mp, mc);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mp, mc);
      for (int i = 0; i < N; i++) begin
        step_for(mp, i, 1'($urandom_range(0, 1)));
        exp_m = (i < N - 1) ? mp[i+1] : exp_p[0];
        total++; if (bus.M !== exp_m || bus.K !== (i == N - 2))
          begin bad++; $display("FAIL rand_step t=%0d i=%0d got M=%b K=%b exp M=%b K=%b", t, i, bus.M, bus.K, exp_m, (i == N - 2)); end
      end
      total++; if (bus.Product !== exp_p)
        begin bad++; $display("FAIL rand_product mp=%h mc=%h got=%h exp=%h", mp, mc, bus.Product, exp_p); end
    end
  endtask

  initial begin
    bus.Load = 1'b0; bus.Rshift = 1'b0; bus.AddRshift = 1'b0; bus.Cm = 1'b0;
    bus.Mplier = '0; bus.Mcand = '0;
    @(posedge CLK);
    #1;
    test_reset();
    test_neg_times_pos();
    test_most_negative();
    test_m_tracking();
    test_mid_reset_load();
    test_idle_hold();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Shift-add signed (two's complement) multiplier datapath.
- Sits directly downstream of the multiplier controller. It consumes the controller's Load, Rshift, AddRshift and Cm strobes.
- It returns M (current multiplier LSB) and K (last-step flag) to the controller, and presents the 2N-bit product.

Parameters:
- N, 4, operand width in bits (N >= 2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Load  input  1  capture operands, clear accumulator and step counter
- Rshift  input  1  arithmetic right shift of {A,Q}, count one step
- AddRshift  input  1  add/subtract multiplicand into A, then shift, count one step
- Cm  input  1  qualifies AddRshift: 0 = add Mcand, 1 = subtract Mcand
- Mplier  input  N  signed multiplier operand, sampled on Load
- Mcand  input  N  signed multiplicand operand, sampled on Load
- M  output  1  Q[0], the current multiplier bit under examination
- K  output  1  high when the step counter equals N-1 (next step is the final one)
- Product  output  2N  {A,Q}, the signed product once the controller signals Done

Behaviour:
- State registers:
  - A: N-bit accumulator.
  - Q: N-bit multiplier/low-product register.
  - B: N-bit multiplicand register.
  - cnt: counter of width clog2(N).
- Reset (sync, highest priority): A, Q, B and cnt all 0. Hence M=0, Product=0, K=0.
- Control priority when more than one strobe is high (protocol error, but defined): Reset > Load > AddRshift > Rshift. Cm is ignored unless AddRshift wins.
- No strobe asserted: all registers hold.
- Load: A<=0, Q<=Mplier, B<=Mcand, cnt<=0.
- Rshift:
  - A<={A[N-1],A[N-1:1]} (arithmetic shift), Q<={A[0],Q[N-1:1]}.
  - cnt<=cnt+1.
- AddRshift:
  - Operand: sum = sext(A) + (Cm ? -sext(B) : sext(B)), computed in N+1 bits. No overflow is possible, including B = -2^(N-1).
  - A<=sum[N:1], Q<={sum[0],Q[N-1:1]}, cnt<=cnt+1.
- Counter wraps modulo N: after the step taken at cnt=N-1, cnt returns to 0 and K drops.
- Outputs M, K and Product are purely registered-state decodes. They take effect the cycle after the causing edge, with no combinational path from inputs.
- Latency:
  - Load edge, then N step edges, gives the final Product.
  - The controller asserts Cm with AddRshift only on the final step (K=1) when M=1.
  - One step strobe per cycle.
- Reset mid-operation: clears on the next edge regardless of any active strobe. The partial product is discarded.
- Load mid-operation: restarts cleanly. Prior A, Q and cnt are discarded.

Test Plan:
- Reset with Load=1 and Mplier=4'hF asserted together -> after edge A=Q=B=0, cnt=0, M=0, K=0, Product=8'h00.
- Load Mplier=4'b1011 (-5), Mcand=4'b0011 (3) -> M=1, K=0.
  - Then drive the controller-correct sequence: AddRshift, AddRshift, Rshift, AddRshift+Cm.
  - Required: K=1 exactly after the 3rd step; final Product=8'hF1 (-15), K=0.
- Load Mplier=4'b1000, Mcand=4'b1000 (-8 x -8) -> Rshift x3, then AddRshift+Cm -> Product=8'h40 (+64). This checks negation of the most-negative multiplicand.
- Load Mplier=4'b0101 (5), Mcand=4'b0011 (3) -> AddRshift, Rshift, AddRshift, Rshift -> Product=8'h0F. Also check M tracks Q[0] after every step (1,0,1,0).
- Mid-operation: after 2 steps of the previous case, assert Reset -> all zero next cycle. Assert Load with Mcand=4'b1111 and Mplier=4'b0001 with Rshift also high: Load wins, Q=4'b0001, cnt=0.
- Idle hold: with no strobes for 5 cycles after completion, Product, M and K remain unchanged.
